// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-command bundle for the two-port data-memory arbiter.
// The slave modport is the arbiter; the master side is the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int N = 32
);
    logic         p0_req;
    logic         p0_we;
    logic         p0_byte;
    logic         p0_signed;
    logic [N-1:0] p0_addr;
    logic [N-1:0] p0_wdata;
    logic         p1_req;
    logic         p1_we;
    logic         p1_byte;
    logic         p1_signed;
    logic [N-1:0] p1_addr;
    logic [N-1:0] p1_wdata;
    logic         p0_ack;
    logic         p1_ack;
    logic [N-1:0] rsp_rdata;
    logic         rsp_err;
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_in_data;
    logic [N-1:0] mem_out_data;
    logic         mem_read_enable;
    logic         mem_write_enable;
    logic         mem_isByte;

    modport slave (
        input  p0_req, p0_we, p0_byte, p0_signed, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_byte, p1_signed, p1_addr, p1_wdata,
        input  mem_out_data,
        output p0_ack, p1_ack, rsp_rdata, rsp_err,
        output mem_address, mem_in_data, mem_read_enable, mem_write_enable, mem_isByte
    );

    modport master (
        output p0_req, p0_we, p0_byte, p0_signed, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_byte, p1_signed, p1_addr, p1_wdata,
        output mem_out_data,
        input  p0_ack, p1_ack, rsp_rdata, rsp_err,
        input  mem_address, mem_in_data, mem_read_enable, mem_write_enable, mem_isByte
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the byte-addressed data memory.
// One registered memory command per grant; every access ends with a one-cycle ack.
module dmem_arbiter #(
    parameter int N          = 32,
    parameter int ADDR_WIDTH = 12
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MAX = ADDR_WIDTH'((1 << ADDR_WIDTH) - 4);

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         port_q, port_d;
    logic         signed_q, signed_d;
    logic         mem_re_q, mem_re_d;
    logic         mem_we_q, mem_we_d;
    logic         mem_is_byte_q, mem_is_byte_d;
    logic [N-1:0] mem_address_q, mem_address_d;
    logic [N-1:0] mem_in_data_q, mem_in_data_d;
    logic [N-1:0] rsp_rdata_q, rsp_rdata_d;
    logic         rsp_err_q, rsp_err_d;
    logic         p0_ack_q, p0_ack_d;
    logic         p1_ack_q, p1_ack_d;

    logic         gnt;
    logic         g_we, g_byte, g_signed, g_err;
    logic [N-1:0] g_addr, g_wdata;

    function automatic logic [N-1:0] extend_byte(input logic [7:0] b, input logic sgn);
        return {{(N-8){sgn & b[7]}}, b};
    endfunction

    // On a tie the port that did not win last time is chosen.
    assign gnt      = (bus.p0_req && bus.p1_req) ? !last_grant_q : bus.p1_req;
    assign g_we     = gnt ? bus.p1_we     : bus.p0_we;
    assign g_byte   = gnt ? bus.p1_byte   : bus.p0_byte;
    assign g_signed = gnt ? bus.p1_signed : bus.p0_signed;
    assign g_addr   = gnt ? bus.p1_addr   : bus.p0_addr;
    assign g_wdata  = gnt ? bus.p1_wdata  : bus.p0_wdata;
    assign g_err    = (g_addr[N-1:ADDR_WIDTH] != '0) ||
                      (!g_byte && (g_addr[1:0] != 2'b00)) ||
                      (!g_byte && (g_addr[ADDR_WIDTH-1:0] > WORD_MAX));

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        port_d        = port_q;
        signed_d      = signed_q;
        mem_re_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_is_byte_d = mem_is_byte_q;
        mem_address_d = mem_address_q;
        mem_in_data_d = mem_in_data_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        p0_ack_d      = 1'b0;
        p1_ack_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.p0_req || bus.p1_req) begin
                    port_d = gnt;
                    if (bus.p0_req && bus.p1_req) last_grant_d = gnt;
                    if (g_err) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        p0_ack_d    = !gnt;
                        p1_ack_d    = gnt;
                        state_d     = RESP;
                    end else begin
                        mem_address_d = g_addr;
                        mem_in_data_d = g_wdata;
                        mem_is_byte_d = g_byte;
                        mem_re_d      = !g_we;
                        mem_we_d      = g_we;
                        signed_d      = g_signed;
                        state_d       = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // The memory acted on the mid-cycle negedge; its read data is settled here.
                p0_ack_d  = !port_q;
                p1_ack_d  = port_q;
                rsp_err_d = 1'b0;
                if (mem_re_q) begin
                    rsp_rdata_d = mem_is_byte_q ? extend_byte(bus.mem_out_data[7:0], signed_q)
                                                : bus.mem_out_data;
                end else begin
                    rsp_rdata_d = '0;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            port_q        <= 1'b0;
            signed_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_is_byte_q <= 1'b0;
            mem_address_q <= '0;
            mem_in_data_q <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            port_q        <= port_d;
            signed_q      <= signed_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            mem_is_byte_q <= mem_is_byte_d;
            mem_address_q <= mem_address_d;
            mem_in_data_q <= mem_in_data_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            p0_ack_q      <= p0_ack_d;
            p1_ack_q      <= p1_ack_d;
        end
    end

    assign bus.p0_ack           = p0_ack_q;
    assign bus.p1_ack           = p1_ack_q;
    assign bus.rsp_rdata        = rsp_rdata_q;
    assign bus.rsp_err          = rsp_err_q;
    assign bus.mem_address      = mem_address_q;
    assign bus.mem_in_data      = mem_in_data_q;
    assign bus.mem_read_enable  = mem_re_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_isByte       = mem_is_byte_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed accesses plus randomized two-port traffic,
// checked against a byte-array model of memory contents and the arbitration order.
module tb_dmem_arbiter;
    localparam int N  = 32;
    localparam int AW = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.N(N)) bus ();
    dmem_arbiter #(.N(N), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory device: acts on the falling edge, junk in upper bits on byte reads.
    logic [7:0] mem [4096] = '{default: 8'h00};
    always @(negedge clk) begin
        if (bus.mem_write_enable) begin
            if (bus.mem_isByte) mem[bus.mem_address[11:0]] <= bus.mem_in_data[7:0];
            else for (int i = 0; i < 4; i++)
                mem[bus.mem_address[11:0] + 12'(i)] <= bus.mem_in_data[8*i +: 8];
        end
        if (bus.mem_read_enable) begin
            if (bus.mem_isByte) bus.mem_out_data <= {24'($urandom), mem[bus.mem_address[11:0]]};
            else bus.mem_out_data <= {mem[bus.mem_address[11:0] + 12'd3], mem[bus.mem_address[11:0] + 12'd2],
                                      mem[bus.mem_address[11:0] + 12'd1], mem[bus.mem_address[11:0]]};
        end
    end

    // Reference contents, updated only when a write is expected to complete.
    logic [7:0] ref_mem [4096];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_err(input bit byt, input logic [31:0] a);
        return (a >= 32'd4096) || (!byt && ((a % 4) != 0 || a > 32'd4092));
    endfunction

    task automatic model(input bit we, input bit byt, input bit sgn, input logic [31:0] a,
                         input logic [31:0] wd, output bit e, output logic [31:0] rd);
        e  = is_err(byt, a);
        rd = 32'd0;
        if (!e) begin
            if (we) begin
                if (byt) ref_mem[a[11:0]] = wd[7:0];
                else for (int i = 0; i < 4; i++) ref_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
            end else if (byt) begin
                rd = {24'd0, ref_mem[a[11:0]]};
                if (sgn && rd >= 32'd128) rd = rd + 32'hFFFF_FF00;
            end else begin
                rd = 0;
                for (int i = 0; i < 4; i++) rd = rd + (32'(ref_mem[a[11:0] + 12'(i)]) << (8 * i));
            end
        end
    endtask

    task automatic drive(input int p, input bit req, input bit we, input bit byt, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_byte = byt;
            bus.p0_signed = sgn; bus.p0_addr = addr; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_byte = byt;
            bus.p1_signed = sgn; bus.p1_addr = addr; bus.p1_wdata = wd;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_p0ack"}, 32'(bus.p0_ack), 32'd0);
        check({tag, "_p1ack"}, 32'(bus.p1_ack), 32'd0);
        check({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_addr"}, bus.mem_address, 32'd0);
        check({tag, "_wdata"}, bus.mem_in_data, 32'd0);
        check({tag, "_en"}, {30'd0, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
        check({tag, "_isbyte"}, 32'(bus.mem_isByte), 32'd0);
    endtask

    // One isolated request from an idle arbiter; req drops on the cycle ack is seen.
    task automatic issue(input int p, input bit we, input bit byt, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
        bit e; logic [31:0] rd; bit got;
        int cycles, wr_n, rd_n, oth;
        model(we, byt, sgn, addr, wd, e, rd);
        drive(p, 1'b1, we, byt, sgn, addr, wd);
        cycles = 0; got = 0; wr_n = 0; rd_n = 0; oth = 0;
        while (!got && cycles < 10) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.mem_write_enable) wr_n++;
            if (bus.mem_read_enable) rd_n++;
            if ((p == 0) ? bus.p1_ack : bus.p0_ack) oth++;
            got = (p == 0) ? bus.p0_ack : bus.p1_ack;
        end
        drive(p, 1'b0, we, byt, sgn, addr, wd);
        check({tag, "_ack"}, 32'(got), 32'd1);
        check({tag, "_latency"}, cycles, e ? 32'd1 : 32'd2);
        check({tag, "_rdata"}, bus.rsp_rdata, rd);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(e));
        check({tag, "_wr_pulses"}, wr_n, 32'(!e && we));
        check({tag, "_rd_pulses"}, rd_n, 32'(!e && !we));
        check({tag, "_other_ack"}, oth, 32'd0);
        @(posedge clk); #1;
    endtask

    bit          q_we [2];
    bit          q_byte [2];
    bit          q_sgn [2];
    logic [31:0] q_addr [2];
    logic [31:0] q_wd [2];

    task automatic new_req(input int p);
        int r;
        r         = int'($urandom_range(0, 9));
        q_we[p]   = 1'($urandom);
        q_byte[p] = 1'($urandom);
        q_sgn[p]  = 1'($urandom);
        q_wd[p]   = $urandom;
        if (r == 0)      q_addr[p] = 32'h1000 + $urandom_range(0, 7);
        else if (r == 1) q_addr[p] = 32'h100 + $urandom_range(0, 63);
        else if (r == 2) q_addr[p] = 32'hFF8 + $urandom_range(0, 7);
        else             q_addr[p] = q_byte[p] ? 32'h100 + $urandom_range(0, 63)
                                               : 32'h100 + 4 * $urandom_range(0, 15);
        drive(p, 1'b1, q_we[p], q_byte[p], q_sgn[p], q_addr[p], q_wd[p]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("ack_exclusive", 32'(bus.p0_ack & bus.p1_ack), 32'd0);
            check("en_exclusive", 32'(bus.mem_read_enable & bus.mem_write_enable), 32'd0);
        end
    end

    logic [31:0] bb_addr [4] = '{32'h10, 32'h21, 32'h11, 32'h14};
    bit          bb_byte [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        bit e; logic [31:0] rd; bit got;
        int w, gp, exp_p, last, p0_acks, acks_seen;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #3;
        check_idle_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, "wr_word_10");
        issue(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, "rd_word_10");
        issue(0, 1'b1, 1'b1, 1'b0, 32'h21, 32'h85, "wr_byte_21");
        issue(0, 1'b0, 1'b1, 1'b1, 32'h21, 32'h0, "rd_sbyte_21");
        issue(1, 1'b0, 1'b1, 1'b0, 32'h21, 32'h0, "rd_ubyte_21");
        issue(0, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, "err_misaligned");
        issue(0, 1'b0, 1'b0, 1'b0, 32'hFFE, 32'h0, "err_word_ffe");
        issue(1, 1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, "err_byte_1000");
        issue(0, 1'b1, 1'b0, 1'b0, 32'h8000_0010, 32'h1, "err_high_bits");
        issue(1, 1'b1, 1'b0, 1'b0, 32'hFFC, 32'hCAFEF00D, "wr_word_ffc");
        issue(0, 1'b0, 1'b1, 1'b0, 32'hFFF, 32'h0, "rd_byte_fff");
        issue(1, 1'b0, 1'b0, 1'b0, 32'hFFC, 32'h0, "rd_word_ffc");

        // Reset lands in the ACCESS cycle of a write, before the falling edge.
        drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h12345678);
        @(posedge clk); #1;
        check("abort_we_before", 32'(bus.mem_write_enable), 32'd1);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h12345678);
        #1;
        check_idle_outputs("abort");
        acks_seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.p0_ack || bus.p1_ack) acks_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.p0_ack || bus.p1_ack) acks_seen++;
        end
        check("abort_no_ack", acks_seen, 32'd0);
        issue(0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, "rd_after_abort");

        // Port 1 alone, back-to-back reads presenting the next request on each ack.
        p0_acks = 0;
        drive(1, 1'b1, 1'b0, bb_byte[0], 1'b1, bb_addr[0], 32'd0);
        last = cyc;
        for (int k = 0; k < 4; k++) begin
            got = 0; w = 0;
            while (!got && w < 10) begin
                @(posedge clk); #1;
                w++;
                if (bus.p0_ack) p0_acks++;
                got = bus.p1_ack;
            end
            model(1'b0, bb_byte[k], 1'b1, bb_addr[k], 32'd0, e, rd);
            check("b2b_ack", 32'(got), 32'd1);
            check("b2b_rdata", bus.rsp_rdata, rd);
            check("b2b_spacing", cyc - last, (k == 0) ? 32'd2 : 32'd3);
            last = cyc;
            if (k < 3) drive(1, 1'b1, 1'b0, bb_byte[k+1], 1'b1, bb_addr[k+1], 32'd0);
            else       drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        check("b2b_p0_silent", p0_acks, 32'd0);
        @(posedge clk); #1;

        // Fresh reset so the first tie must go to port 0, then random contention.
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("reset2");
        rst_n = 1'b1;
        @(posedge clk); #1;
        new_req(0);
        new_req(1);
        exp_p = 0;
        for (int k = 0; k < 30; k++) begin
            got = 0; w = 0;
            while (!got && w < 10) begin
                @(posedge clk); #1;
                w++;
                got = bus.p0_ack | bus.p1_ack;
            end
            check("arb_ack", 32'(got), 32'd1);
            if (got) begin
                gp = bus.p1_ack ? 1 : 0;
                check("arb_order", gp, exp_p);
                model(q_we[gp], q_byte[gp], q_sgn[gp], q_addr[gp], q_wd[gp], e, rd);
                check("arb_rdata", bus.rsp_rdata, rd);
                check("arb_err", 32'(bus.rsp_err), 32'(e));
                new_req(gp);
                exp_p = 1 - gp;
            end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the byte-addressed data memory. The memory is negedge-sampled and 8 bits wide per location. Port 0 serves the pipeline MEM stage; port 1 serves the loader/DMA path. The block grants one request at a time (round-robin), checks alignment and range, drives a single registered memory command, and captures and extends read data. Each access completes with a one-cycle ack pulse.

Parameters:
N, 32, address and data width
ADDR_WIDTH, 12, implemented memory address bits; valid bytes are 0 .. 2^ADDR_WIDTH-1

Ports:
clk  in  1  system clock; rising edge for all state
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held until p0_ack
p0_we  in  1  port 0 write (1) / read (0)
p0_byte  in  1  port 0 byte access (1) / word access (0)
p0_signed  in  1  port 0 sign-extend byte read
p0_addr  in  N  port 0 byte address
p0_wdata  in  N  port 0 write data
p1_req, p1_we, p1_byte, p1_signed, p1_addr, p1_wdata  in  1/1/1/1/N/N  same meaning for port 1
p0_ack  out  1  port 0 completion pulse
p1_ack  out  1  port 1 completion pulse
rsp_rdata  out  N  read data; valid while either ack is high
rsp_err  out  1  error flag; valid while either ack is high
mem_address  out  N  memory byte address
mem_in_data  out  N  memory write data
mem_out_data  in  N  memory read data
mem_read_enable  out  1  memory read strobe
mem_write_enable  out  1  memory write strobe
mem_isByte  out  1  memory byte mode

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All outputs 0 immediately: acks, rsp_rdata, rsp_err, all mem_* outputs.
- Reset mid-operation:
  - The access is aborted and no ack is issued.
  - Enables clear asynchronously, so a write is suppressed if rst_n falls before the negedge of the ACCESS cycle.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: hold; mem enables stay 0.
  - Exactly one req: grant that port.
  - Both req: grant the port != last_grant; set last_grant = granted port.
  - Check the granted request:
    - Error if addr[N-1:ADDR_WIDTH] != 0.
    - Error if word access and addr[1:0] != 0.
    - Error if word access and addr[ADDR_WIDTH-1:0] > 2^ADDR_WIDTH-4.
  - OK: register mem_address=addr, mem_in_data=wdata, mem_isByte=byte; mem_read_enable=!we, mem_write_enable=we; next ACCESS. Latch signed and port id.
  - Error: mem enables stay 0; rsp_err=1, rsp_rdata=0, ack[port]=1; next RESP.
- ACCESS (exactly one cycle):
  - Enables are high for the whole cycle; the memory acts on the mid-cycle negedge.
  - At the next rising edge: enables go 0; ack[port]=1, rsp_err=0; next RESP.
  - rsp_rdata update:
    - word read: rsp_rdata = mem_out_data.
    - byte read: rsp_rdata = {24 copies of bit7 if signed else 0, mem_out_data[7:0]}. Upper input bits are ignored (may be Z).
    - write: rsp_rdata = 0.
- RESP (one cycle):
  - Ack is high during this cycle.
  - At the next edge: ack=0; rsp_rdata and rsp_err hold; next IDLE.
  - Requests are not sampled in RESP.
- Requester rule: deassert req (or present a new request) on the edge where ack is seen high. A req still high in the following IDLE is treated as a new request.
- Latency: good access takes 3 cycles request-to-IDLE, with ack at cycle 2; error takes 2 cycles, with ack at cycle 1.
- Inputs are sampled only in IDLE. Changes to a request's inputs while it is in flight have no effect.
- At most one of p0_ack and p1_ack is high in any cycle; both enables are never high together.

Test Plan:
- Reset then p0 word write addr=0x10 wdata=0xDEADBEEF, then p0 word read 0x10 -> mem_write_enable high one cycle, p0_ack 2 cycles after req, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte write 0x85 to addr 0x21; byte read with signed=1 -> rsp_rdata=0xFFFFFF85; with signed=0 -> 0x00000085.
- p0 and p1 req in the same cycle, both held continuously -> grants alternate p0,p1,p0,p1; never both acks; last_grant starts favouring p0.
- Word read addr=0x13 -> rsp_err=1, rsp_rdata=0, no mem enable pulse, ack one cycle after req. Word read 0xFFE and byte read 0x1000 (ADDR_WIDTH=12) -> rsp_err=1.
- Assert rst_n=0 during ACCESS of a write to 0x40 before the negedge -> enables drop immediately, no ack, subsequent read of 0x40 returns the old value 0.
- p1 alone issues 4 back-to-back reads dropping req on ack -> one access per 3 cycles, p0_ack never asserts.
